// File: rtl/i2s_adc_capture.sv
// Oversampling I2S ADC receiver: synchronises the codec pins into CLOCK_50 and
// deserialises each left/right pair into one 32-bit FIFO write.
module i2s_adc_capture #(
  parameter int SAMPLE_BITS = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        AUD_BCLK,
  input  logic        AUD_ADC_LRCK,
  input  logic        AUD_ADC_DAT,
  input  logic        wrfull,
  output logic        wrreq,
  output logic [31:0] data,
  output logic [15:0] overflow_count,
  output logic [7:0]  frame_err_count
);

  localparam logic [4:0] LAST_BIT = 5'(SAMPLE_BITS - 1);

  typedef enum logic [1:0] {ALIGN, SHIFT, HOLD} state_t;

  logic [2:0]  sync_q [SYNC_STAGES];
  logic        bclk_s, lr_s, dat_s;
  logic        bclk_prev_q, lr_prev_q;
  logic        bclk_rise, lr_change;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        chan_q, chan_d;
  logic [15:0] sh_q, sh_d, sh_ins;
  logic [15:0] left_q, left_d;
  logic        left_valid_q, left_valid_d;
  logic        pair_done, frame_err;
  logic [31:0] pair_word;

  // NOTE: synchroniser flops are ordinary registers, so they take the async
  // reset like everything else; only true RAM arrays would be left unreset.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {AUD_BCLK, AUD_ADC_LRCK, AUD_ADC_DAT};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {bclk_s, lr_s, dat_s} = sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  assign lr_change = lr_s ^ lr_prev_q;
  assign sh_ins    = sh_q | (dat_s ? (16'h8000 >> cnt_q) : 16'h0000);
  assign pair_word = {left_q, sh_ins};

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    chan_d       = chan_q;
    sh_d         = sh_q;
    left_d       = left_q;
    left_valid_d = left_valid_q;
    pair_done    = 1'b0;
    frame_err    = 1'b0;
    if (bclk_rise) begin
      // The rise that reveals an LRCK edge is the I2S one-bit delay slot, so
      // shifting for the new channel starts on the following rise.
      unique case (state_q)
        ALIGN: begin
          if (lr_change && !lr_s) begin
            state_d = SHIFT;
            cnt_d   = '0;
            chan_d  = 1'b0;
            sh_d    = '0;
          end
        end
        SHIFT: begin
          if (lr_change && cnt_q != LAST_BIT) begin
            frame_err    = 1'b1;
            left_valid_d = 1'b0;
            cnt_d        = '0;
            chan_d       = lr_s;
            sh_d         = '0;
          end else begin
            sh_d  = sh_ins;
            cnt_d = 5'(cnt_q + 5'd1);
            if (cnt_q == LAST_BIT) begin
              if (!chan_q) begin
                left_d       = sh_ins;
                left_valid_d = 1'b1;
              end else if (left_valid_q) begin
                pair_done    = 1'b1;
                left_valid_d = 1'b0;
              end
              // LSB landing on the LRCK edge completes and restarts at once.
              if (lr_change) begin
                cnt_d  = '0;
                chan_d = lr_s;
                sh_d   = '0;
              end else begin
                state_d = HOLD;
              end
            end
          end
        end
        HOLD: begin
          if (lr_change) begin
            state_d = SHIFT;
            cnt_d   = '0;
            chan_d  = lr_s;
            sh_d    = '0;
          end
        end
        default: state_d = ALIGN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      bclk_prev_q     <= 1'b0;
      lr_prev_q       <= 1'b0;
      state_q         <= ALIGN;
      cnt_q           <= '0;
      chan_q          <= 1'b0;
      sh_q            <= '0;
      left_q          <= '0;
      left_valid_q    <= 1'b0;
      wrreq           <= 1'b0;
      data            <= '0;
      overflow_count  <= '0;
      frame_err_count <= '0;
    end else begin
      bclk_prev_q  <= bclk_s;
      if (bclk_rise) lr_prev_q <= lr_s;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      chan_q       <= chan_d;
      sh_q         <= sh_d;
      left_q       <= left_d;
      left_valid_q <= left_valid_d;
      wrreq        <= 1'b0;
      // wrfull is taken on the completing rise; wrreq shows one clock later.
      if (pair_done) begin
        if (wrfull) begin
          if (overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
        end else begin
          wrreq <= 1'b1;
          data  <= pair_word;
        end
      end
      if (frame_err && frame_err_count != 8'hFF)
        frame_err_count <= frame_err_count + 8'd1;
    end
  end

endmodule
